uart_fifo_mmio: RTL and testbench

UART_FIFO_MMIO -- requirements
Module: uart_fifo_mmio

---
 rtl/uart_fifo_mmio.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_mmio.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_mmio.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, a programmable bit divisor and a
// level interrupt, exposed as a four-register window on a simple strobe bus.
module uart_fifo_mmio #(
   parameter logic [7:0] BASE_ADDR   = 8'h80,
   parameter int         TX_DEPTH    = 8,
   parameter int         RX_DEPTH    = 8,
   parameter logic [7:0] DEFAULT_DIV = 8'd16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bus_cs,
   input  logic       bus_we,
   input  logic [7:0] bus_addr,
   input  logic [7:0] bus_wdata,
   output logic [7:0] bus_rdata,
   output logic       uart_tx,
   input  logic       uart_rx,
   output logic       irq
);

   localparam int TXAW = $clog2(TX_DEPTH);
   localparam int RXAW = $clog2(RX_DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uartState_t;

   logic [7:0] offset;
   logic       inWin, wrAcc, rdAcc;
   logic       wrData, wrStatus, wrCtrl, wrDiv, rdData;
   logic       txFlush, rxFlush;
   logic [7:0] div_q, effDiv;
   logic       rxIrqEn_q, txIrqEn_q, overrun_q, frameErr_q;

   // Bus decode; the lower-bound test keeps addresses below the window from wrapping in
   assign offset   = bus_addr - BASE_ADDR;
   assign inWin    = (bus_addr >= BASE_ADDR) && (offset < 8'd4);
   assign wrAcc    = bus_cs & bus_we & inWin;
   assign rdAcc    = bus_cs & ~bus_we & inWin;
   assign wrData   = wrAcc && (offset[1:0] == 2'd0);
   assign wrStatus = wrAcc && (offset[1:0] == 2'd1);
   assign wrCtrl   = wrAcc && (offset[1:0] == 2'd2);
   assign wrDiv    = wrAcc && (offset[1:0] == 2'd3);
   assign rdData   = rdAcc && (offset[1:0] == 2'd0);
   assign txFlush  = wrCtrl & bus_wdata[2];
   assign rxFlush  = wrCtrl & bus_wdata[3];
   assign effDiv   = (div_q < 8'd4) ? 8'd4 : div_q;

   // ---------------- TX FIFO ----------------
   logic [7:0]      txMem_q [TX_DEPTH];
   logic [TXAW-1:0] txWr_q, txRd_q;
   logic [TXAW:0]   txCnt_q;
   logic            txFull, txEmpty, txPush, txPop;

   assign txFull  = (txCnt_q == (TXAW+1)'(TX_DEPTH));
   assign txEmpty = (txCnt_q == '0);
   assign txPush  = wrData & ~txFull & ~txFlush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txWr_q  <= '0;
         txRd_q  <= '0;
         txCnt_q <= '0;
      end else if (txFlush) begin
         txWr_q  <= '0;
         txRd_q  <= '0;
         txCnt_q <= '0;
      end else begin
         if (txPush) txWr_q <= txWr_q + 1'b1;
         if (txPop)  txRd_q <= txRd_q + 1'b1;
         txCnt_q <= txCnt_q + (TXAW+1)'(txPush) - (TXAW+1)'(txPop);
      end
   end

   always_ff @(posedge clk) begin
      if (txPush) txMem_q[txWr_q] <= bus_wdata;
   end

   // ---------------- TX serializer ----------------
   uartState_t txState_q, txState_d;
   logic [7:0] txTick_q, txTick_d, txShift_q, txShift_d, txDiv_q, txDiv_d;
   logic [2:0] txBit_q, txBit_d;
   logic       txLevel, txLine_q, txTickEnd;

   assign txTickEnd = (txTick_q == txDiv_q - 8'd1);

   always_comb begin
      txState_d = txState_q;
      txTick_d  = txTick_q + 8'd1;
      txShift_d = txShift_q;
      txDiv_d   = txDiv_q;
      txBit_d   = txBit_q;
      txPop     = 1'b0;
      txLevel   = 1'b1;
      case (txState_q)
         ST_IDLE: begin
            txTick_d = '0;
            if (!txEmpty) begin
               txPop     = 1'b1;
               txShift_d = txMem_q[txRd_q];
               txDiv_d   = effDiv;
               txState_d = ST_START;
            end
         end
         ST_START: begin
            txLevel = 1'b0;
            if (txTickEnd) begin
               txTick_d  = '0;
               txBit_d   = '0;
               txState_d = ST_DATA;
            end
         end
         ST_DATA: begin
            txLevel = txShift_q[0];
            if (txTickEnd) begin
               txTick_d  = '0;
               txShift_d = {1'b0, txShift_q[7:1]};
               txBit_d   = txBit_q + 3'd1;
               if (txBit_q == 3'd7) txState_d = ST_STOP;
            end
         end
         default: begin
            if (txTickEnd) begin
               txTick_d  = '0;
               txState_d = ST_IDLE;
               if (!txEmpty) begin
                  txPop     = 1'b1;
                  txShift_d = txMem_q[txRd_q];
                  txDiv_d   = effDiv;
                  txState_d = ST_START;
               end
            end
         end
      endcase
   end

   // The line is registered, which gives the two-edge write-to-start-bit latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txState_q <= ST_IDLE;
         txTick_q  <= '0;
         txShift_q <= '0;
         txDiv_q   <= 8'd4;
         txBit_q   <= '0;
         txLine_q  <= 1'b1;
      end else begin
         txState_q <= txState_d;
         txTick_q  <= txTick_d;
         txShift_q <= txShift_d;
         txDiv_q   <= txDiv_d;
         txBit_q   <= txBit_d;
         txLine_q  <= txLevel;
      end
   end

   assign uart_tx = txLine_q;

   // ---------------- RX deserializer ----------------
   uartState_t rxState_q, rxState_d;
   logic [7:0] rxTick_q, rxTick_d, rxShift_q, rxShift_d, rxDiv_q, rxDiv_d;
   logic [2:0] rxBit_q, rxBit_d;
   logic       rxSync1_q, rxSync2_q, rxPrev_q, rxFall, rxDone;

   assign rxFall = rxPrev_q & ~rxSync2_q;

   always_comb begin
      rxState_d = rxState_q;
      rxTick_d  = rxTick_q + 8'd1;
      rxShift_d = rxShift_q;
      rxDiv_d   = rxDiv_q;
      rxBit_d   = rxBit_q;
      rxDone    = 1'b0;
      case (rxState_q)
         ST_IDLE: begin
            rxTick_d = '0;
            if (rxFall) begin
               rxDiv_d   = effDiv;
               rxState_d = ST_START;
            end
         end
         ST_START: begin
            if (rxTick_q == (rxDiv_q >> 1) - 8'd1) begin
               rxTick_d  = '0;
               rxBit_d   = '0;
               rxState_d = rxSync2_q ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (rxTick_q == rxDiv_q - 8'd1) begin
               rxTick_d  = '0;
               rxShift_d = {rxSync2_q, rxShift_q[7:1]};
               rxBit_d   = rxBit_q + 3'd1;
               if (rxBit_q == 3'd7) rxState_d = ST_STOP;
            end
         end
         default: begin
            if (rxTick_q == rxDiv_q - 8'd1) begin
               rxDone    = 1'b1;
               rxState_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxSync1_q <= 1'b1;
         rxSync2_q <= 1'b1;
         rxPrev_q  <= 1'b1;
         rxState_q <= ST_IDLE;
         rxTick_q  <= '0;
         rxShift_q <= '0;
         rxDiv_q   <= 8'd4;
         rxBit_q   <= '0;
      end else begin
         rxSync1_q <= uart_rx;
         rxSync2_q <= rxSync1_q;
         rxPrev_q  <= rxSync2_q;
         rxState_q <= rxState_d;
         rxTick_q  <= rxTick_d;
         rxShift_q <= rxShift_d;
         rxDiv_q   <= rxDiv_d;
         rxBit_q   <= rxBit_d;
      end
   end

   // ---------------- RX FIFO ----------------
   logic [7:0]      rxMem_q [RX_DEPTH];
   logic [RXAW-1:0] rxWr_q, rxRd_q;
   logic [RXAW:0]   rxCnt_q;
   logic            rxFull, rxEmpty, rxPush, rxPop, rxGood, overrunEvt, frameErrEvt;

   assign rxFull      = (rxCnt_q == (RXAW+1)'(RX_DEPTH));
   assign rxEmpty     = (rxCnt_q == '0);
   assign rxPop       = rdData & ~rxEmpty;
   assign rxGood      = rxDone & rxSync2_q;
   // A same-cycle bus pop frees the slot, so a full FIFO still accepts the byte
   assign rxPush      = rxGood & (~rxFull | rxPop) & ~rxFlush;
   assign overrunEvt  = rxGood & rxFull & ~rxPop;
   assign frameErrEvt = rxDone & ~rxSync2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxWr_q  <= '0;
         rxRd_q  <= '0;
         rxCnt_q <= '0;
      end else if (rxFlush) begin
         rxWr_q  <= '0;
         rxRd_q  <= '0;
         rxCnt_q <= '0;
      end else begin
         if (rxPush) rxWr_q <= rxWr_q + 1'b1;
         if (rxPop)  rxRd_q <= rxRd_q + 1'b1;
         rxCnt_q <= rxCnt_q + (RXAW+1)'(rxPush) - (RXAW+1)'(rxPop);
      end
   end

   always_ff @(posedge clk) begin
      if (rxPush) rxMem_q[rxWr_q] <= rxShift_q;
   end

   // ---------------- Control/status registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxIrqEn_q  <= 1'b0;
         txIrqEn_q  <= 1'b0;
         div_q      <= DEFAULT_DIV;
         overrun_q  <= 1'b0;
         frameErr_q <= 1'b0;
      end else begin
         if (wrCtrl) begin
            rxIrqEn_q <= bus_wdata[0];
            txIrqEn_q <= bus_wdata[1];
         end
         if (wrDiv) div_q <= bus_wdata;
         if (overrunEvt)                    overrun_q <= 1'b1;
         else if (wrStatus && bus_wdata[4]) overrun_q <= 1'b0;
         if (frameErrEvt)                   frameErr_q <= 1'b1;
         else if (wrStatus && bus_wdata[5]) frameErr_q <= 1'b0;
      end
   end

   logic txIdle;
   logic [7:0] status;

   assign txIdle = txEmpty & (txState_q == ST_IDLE);
   assign status = {2'b00, frameErr_q, overrun_q, rxFull, ~rxEmpty, txIdle, txFull};

   always_comb begin
      bus_rdata = 8'h00;
      if (rdAcc) begin
         case (offset[1:0])
            2'd0:    bus_rdata = rxEmpty ? 8'h00 : rxMem_q[rxRd_q];
            2'd1:    bus_rdata = status;
            2'd2:    bus_rdata = {6'b0, txIrqEn_q, rxIrqEn_q};
            default: bus_rdata = div_q;
         endcase
      end
   end

   assign irq = (rxIrqEn_q & (~rxEmpty | overrun_q | frameErr_q)) | (txIrqEn_q & txIdle);

endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Scoreboard bench for uart_fifo_mmio: bus reads and serial TX frames are
// queued as expectations and checked by independent monitor processes.
module tb_uart_fifo_mmio;

   localparam logic [7:0] A_DATA = 8'h80;
   localparam logic [7:0] A_STAT = 8'h81;
   localparam logic [7:0] A_CTRL = 8'h82;
   localparam logic [7:0] A_DIV  = 8'h83;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       bus_cs = 1'b0;
   logic       bus_we = 1'b0;
   logic [7:0] bus_addr = 8'h00;
   logic [7:0] bus_wdata = 8'h00;
   logic [7:0] bus_rdata;
   logic       uart_tx, irq;
   logic       rxLine = 1'b1;
   logic       loopback = 1'b0;
   logic       uart_rx;

   assign uart_rx = loopback ? uart_tx : rxLine;

   uart_fifo_mmio #(
      .BASE_ADDR(8'h80),
      .TX_DEPTH(8),
      .RX_DEPTH(8),
      .DEFAULT_DIV(8'd16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus_cs(bus_cs),
      .bus_we(bus_we),
      .bus_addr(bus_addr),
      .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata),
      .uart_tx(uart_tx),
      .uart_rx(uart_rx),
      .irq(irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] val;
      string      name;
   } rdExp_t;

   typedef struct {
      logic [7:0] data;
      int         clks;
      bit         contig;
   } txExp_t;

   rdExp_t rdQ[$];
   txExp_t txQ[$];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", name, actual, expected, cyc);
      end
   endtask

   // Drive tasks are entered on a falling edge and return on the next one.
   task automatic busWrite(input logic [7:0] addr, input logic [7:0] data);
      bus_cs = 1'b1;
      bus_we = 1'b1;
      bus_addr = addr;
      bus_wdata = data;
      @(negedge clk);
      bus_cs = 1'b0;
      bus_we = 1'b0;
   endtask

   task automatic busRead(input logic [7:0] addr, input logic [7:0] expVal, input string name);
      rdExp_t e;
      e.val = expVal;
      e.name = name;
      rdQ.push_back(e);
      bus_cs = 1'b1;
      bus_we = 1'b0;
      bus_addr = addr;
      @(negedge clk);
      bus_cs = 1'b0;
   endtask

   task automatic expectTx(input logic [7:0] data, input int clks, input bit contig);
      txExp_t e;
      e.data = data;
      e.clks = clks;
      e.contig = contig;
      txQ.push_back(e);
   endtask

   task automatic sendRx(input logic [7:0] data, input logic stopBit, input int clks);
      rxLine = 1'b0;
      repeat (clks) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxLine = data[i];
         repeat (clks) @(negedge clk);
      end
      rxLine = stopBit;
      repeat (clks) @(negedge clk);
      rxLine = 1'b1;
   endtask

   // Read monitor: compares bus_rdata against the oldest queued expectation
   rdExp_t rdE;
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (bus_cs && !bus_we) begin
            if (rdQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpectedRead: got %0h, expected no read", bus_rdata);
            end else begin
               rdE = rdQ.pop_front();
               checkOutput(rdE.name, 32'(bus_rdata), 32'(rdE.val));
            end
         end
      end
   end

   // Serial monitor: decodes each frame on uart_tx at the bit period it was queued with
   initial begin
      logic       txPrev;
      txExp_t     te;
      logic [7:0] got;
      int         startCyc, lastStart, prevClks;
      txPrev = 1'b1;
      lastStart = 0;
      prevClks = 0;
      forever begin
         @(negedge clk);
         if (txPrev && !uart_tx) begin
            if (txQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpectedTxFrame: start bit at cycle %0d, expected none", cyc);
            end else begin
               te = txQ.pop_front();
               startCyc = cyc;
               if (te.contig) checkOutput("txFrameGap", 32'(startCyc - lastStart), 32'(10 * prevClks));
               repeat (te.clks / 2) @(negedge clk);
               checkOutput("txStartBit", 32'(uart_tx), 32'd0);
               for (int i = 0; i < 8; i++) begin
                  repeat (te.clks) @(negedge clk);
                  got[i] = uart_tx;
               end
               checkOutput("txDataByte", 32'(got), 32'(te.data));
               repeat (te.clks) @(negedge clk);
               checkOutput("txStopBit", 32'(uart_tx), 32'd1);
               lastStart = startCyc;
               prevClks = te.clks;
            end
         end
         txPrev = uart_tx;
      end
   end

   task automatic applyStimulus();
      // Reset values
      repeat (3) @(negedge clk);
      checkOutput("resetUartTx", 32'(uart_tx), 32'd1);
      checkOutput("resetIrq", 32'(irq), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      busRead(A_STAT, 8'h02, "resetStatus");
      busRead(A_CTRL, 8'h00, "resetCtrl");
      busRead(A_DIV, 8'h10, "resetDiv");
      busRead(A_DATA, 8'h00, "emptyRxRead");
      busRead(8'h84, 8'h00, "aboveWindowRead");
      busRead(8'h7F, 8'h00, "belowWindowRead");
      checkOutput("idleRdata", 32'(bus_rdata), 32'd0);

      // Single frame and write-to-start-bit latency
      expectTx(8'hA5, 16, 1'b0);
      busWrite(A_DATA, 8'hA5);
      @(posedge clk);
      #1 checkOutput("txLatencyEdge1", 32'(uart_tx), 32'd1);
      @(posedge clk);
      #1 checkOutput("txLatencyEdge2", 32'(uart_tx), 32'd0);
      @(negedge clk);
      busRead(A_STAT, 8'h00, "txBusyStatus");
      repeat (180) @(negedge clk);
      busRead(A_STAT, 8'h02, "txIdleStatus");

      // Overfill TX FIFO: last byte dropped, frames back to back
      for (int i = 0; i < 10; i++) begin
         if (i <= 8) expectTx(8'h10 + 8'(i), 16, i > 0);
         busWrite(A_DATA, 8'h10 + 8'(i));
      end
      busRead(A_STAT, 8'h01, "txFullStatus");
      repeat (9 * 160 + 60) @(negedge clk);
      busRead(A_STAT, 8'h02, "txDrainedStatus");

      // Loopback single byte with RX interrupt
      loopback = 1'b1;
      busWrite(A_CTRL, 8'h01);
      checkOutput("irqBeforeRx", 32'(irq), 32'd0);
      expectTx(8'h3C, 16, 1'b0);
      busWrite(A_DATA, 8'h3C);
      repeat (200) @(negedge clk);
      checkOutput("irqRxAvail", 32'(irq), 32'd1);
      busRead(A_DATA, 8'h3C, "loopbackData");
      checkOutput("irqAfterPop", 32'(irq), 32'd0);
      busRead(A_DATA, 8'h00, "loopbackEmptyRead");

      // RX overrun after RX_DEPTH+1 frames
      for (int i = 0; i < 9; i++) begin
         expectTx(8'h41 + 8'(i), 16, i > 0);
         busWrite(A_DATA, 8'h41 + 8'(i));
      end
      repeat (9 * 160 + 80) @(negedge clk);
      busRead(A_STAT, 8'h1E, "overrunStatus");
      busWrite(A_STAT, 8'h10);
      busRead(A_STAT, 8'h0E, "overrunCleared");
      for (int i = 0; i < 8; i++) busRead(A_DATA, 8'h41 + 8'(i), "rxFifoOrder");
      busRead(A_STAT, 8'h02, "rxDrainedStatus");

      // Framing error, glitch rejection and a clean external frame
      loopback = 1'b0;
      sendRx(8'h5A, 1'b0, 16);
      repeat (20) @(negedge clk);
      busRead(A_STAT, 8'h22, "frameErrStatus");
      checkOutput("irqFrameErr", 32'(irq), 32'd1);
      busWrite(A_STAT, 8'h20);
      busRead(A_STAT, 8'h02, "frameErrCleared");
      rxLine = 1'b0;
      repeat (5) @(negedge clk);
      rxLine = 1'b1;
      repeat (40) @(negedge clk);
      busRead(A_STAT, 8'h02, "glitchNoFlags");
      busRead(A_DATA, 8'h00, "glitchNoByte");
      sendRx(8'hC3, 1'b1, 16);
      repeat (20) @(negedge clk);
      busRead(A_DATA, 8'hC3, "rxExternalFrame");

      // Divisor clamp and mid-frame change
      busWrite(A_DIV, 8'h02);
      busRead(A_DIV, 8'h02, "divReadback");
      expectTx(8'h96, 4, 1'b0);
      expectTx(8'h69, 8, 1'b1);
      busWrite(A_DATA, 8'h96);
      busWrite(A_DATA, 8'h69);
      busWrite(A_DIV, 8'h08);
      repeat (150) @(negedge clk);
      busRead(A_STAT, 8'h02, "divFramesDone");
      busRead(A_DIV, 8'h08, "divNewValue");

      // TX flush keeps the frame in flight, drops the queued bytes
      expectTx(8'hE7, 8, 1'b0);
      busWrite(A_DATA, 8'hE7);
      busWrite(A_DATA, 8'h18);
      busWrite(A_DATA, 8'h24);
      busWrite(A_CTRL, 8'h04);
      repeat (120) @(negedge clk);
      busRead(A_STAT, 8'h02, "flushIdleStatus");
      busRead(A_CTRL, 8'h00, "ctrlFlushReadsZero");

      // TX idle interrupt
      busWrite(A_CTRL, 8'h02);
      checkOutput("irqTxIdle", 32'(irq), 32'd1);
      busRead(A_CTRL, 8'h02, "ctrlTxIrqEn");
      repeat (5) @(negedge clk);
   endtask

   initial begin
      applyStimulus();
      checkOutput("txFramesOutstanding", 32'(txQ.size()), 32'd0);
      checkOutput("readsOutstanding", 32'(rdQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
